// File: rtl/demux2_stream_if.sv
// Stream handshake bundle for demux2_stream: one producer port and two consumer ports.
interface demux2_stream_if #(
    parameter int N = 32
);
    logic         S;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] D;
    logic         out0_valid;
    logic         out0_ready;
    logic [N-1:0] Y0;
    logic         out1_valid;
    logic         out1_ready;
    logic [N-1:0] Y1;

    // Environment side: producer plus both consumers
    modport master (
        output S, in_valid, D, out0_ready, out1_ready,
        input  in_ready, out0_valid, Y0, out1_valid, Y1
    );

    modport slave (
        input  S, in_valid, D, out0_ready, out1_ready,
        output in_ready, out0_valid, Y0, out1_valid, Y1
    );
endinterface

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer: each accepted word goes to the slot chosen by S.
// Each output slot is an EMPTY/FULL state machine with its own holding register and drain counter.
//
// state | meaning
// EMPTY | slot holds no deliverable word, outk_valid=0, Yk keeps last delivered word
// FULL  | slot holds a word awaiting consumer k, outk_valid=1
module demux2_stream #(
    parameter int n    = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    demux2_stream_if.slave  bus,
    output logic [CNTW-1:0] count0,
    output logic [CNTW-1:0] count1
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

    slot_t            r_st0, r_st1;
    slot_t            w_nx0, w_nx1;
    logic [n-1:0]     r_y0, r_y1;
    logic [CNTW-1:0]  r_cnt0, r_cnt1;
    logic             w_in_ready;
    logic             w_load0, w_load1;
    logic             w_drain0, w_drain1;
    logic             w_valid0, w_valid1;

    assign w_valid0 = (r_st0 == FULL);
    assign w_valid1 = (r_st1 == FULL);

    assign w_drain0 = w_valid0 & bus.out0_ready;
    assign w_drain1 = w_valid1 & bus.out1_ready;

    // Readiness looks only at the selected slot so a stall on the other port never blocks
    assign w_in_ready = bus.S ? (~w_valid1 | bus.out1_ready)
                              : (~w_valid0 | bus.out0_ready);

    assign w_load0 = bus.in_valid & w_in_ready & ~bus.S;
    assign w_load1 = bus.in_valid & w_in_ready &  bus.S;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_st0 <= EMPTY;
            r_st1 <= EMPTY;
        end else begin
            r_st0 <= w_nx0;
            r_st1 <= w_nx1;
        end
    end

    always_comb begin
        w_nx0 = r_st0;
        w_nx1 = r_st1;
        if (w_load0)
            w_nx0 = FULL;
        else if (w_drain0)
            w_nx0 = EMPTY;
        if (w_load1)
            w_nx1 = FULL;
        else if (w_drain1)
            w_nx1 = EMPTY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_y0 <= '0;
            r_y1 <= '0;
        end else begin
            if (w_load0)
                r_y0 <= bus.D;
            if (w_load1)
                r_y1 <= bus.D;
        end
    end

    // Counters saturate at all-ones; clear wins over a coincident drain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (clear) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_drain0 && (r_cnt0 != '1))
                r_cnt0 <= r_cnt0 + CNTW'(1);
            if (w_drain1 && (r_cnt1 != '1))
                r_cnt1 <= r_cnt1 + CNTW'(1);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out0_valid = w_valid0;
    assign bus.out1_valid = w_valid1;
    assign bus.Y0         = r_y0;
    assign bus.Y1         = r_y1;
    assign count0         = r_cnt0;
    assign count1         = r_cnt1;
endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream with hand-computed expectations (CNTW=4 to reach saturation).
module tb_demux2_stream;
    localparam int N  = 32;
    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic          clear;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;
    int            n_vec;
    int            n_err;

    demux2_stream_if #(.N(N)) bus ();

    demux2_stream #(.n(N), .CNTW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus),
        .count0  (count0),
        .count1  (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic        alt_s [4];
    logic [31:0] alt_d [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        clear = 1'b0;
        bus.S = 1'b0;
        bus.in_valid = 1'b0;
        bus.D = '0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        #12;
        check("rst_v0", {31'b0, bus.out0_valid}, 32'd0);
        check("rst_v1", {31'b0, bus.out1_valid}, 32'd0);
        check("rst_y0", bus.Y0, 32'd0);
        check("rst_cnt0", {28'b0, count0}, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: single word to port 0
        bus.in_valid = 1'b1; bus.S = 1'b0; bus.D = 32'hDEADBEEF; bus.out0_ready = 1'b1;
        #1 check("t1_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("t1_v0", {31'b0, bus.out0_valid}, 32'd1);
        check("t1_y0", bus.Y0, 32'hDEADBEEF);
        check("t1_v1", {31'b0, bus.out1_valid}, 32'd0);
        check("t1_cnt0_pre", {28'b0, count0}, 32'd0);
        tick();
        check("t1_cnt0", {28'b0, count0}, 32'd1);
        check("t1_v0_empty", {31'b0, bus.out0_valid}, 32'd0);
        check("t1_y0_retain", bus.Y0, 32'hDEADBEEF);

        // 2: port 0 stall then drain with simultaneous load
        clear = 1'b1; tick(); clear = 1'b0;
        check("t2_clear", {28'b0, count0}, 32'd0);
        bus.out0_ready = 1'b0;
        bus.in_valid = 1'b1; bus.S = 1'b0; bus.D = 32'h11;
        #1 check("t2_rdy_11", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.D = 32'h22;
        #1 check("t2_rdy_22", {31'b0, bus.in_ready}, 32'd0);
        check("t2_y0_11", bus.Y0, 32'h11);
        tick();
        check("t2_y0_hold", bus.Y0, 32'h11);
        check("t2_v0_hold", {31'b0, bus.out0_valid}, 32'd1);
        bus.out0_ready = 1'b1;
        #1 check("t2_rdy_drain", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("t2_y0_22", bus.Y0, 32'h22);
        check("t2_v0_22", {31'b0, bus.out0_valid}, 32'd1);
        check("t2_cnt0_1", {28'b0, count0}, 32'd1);
        tick();
        check("t2_cnt0_2", {28'b0, count0}, 32'd2);

        // 3: port 0 stalled FULL while port 1 streams
        clear = 1'b1; tick(); clear = 1'b0;
        bus.out0_ready = 1'b0; bus.out1_ready = 1'b1;
        bus.in_valid = 1'b1; bus.S = 1'b0; bus.D = 32'h55;
        tick();
        bus.S = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.D = 32'(i);
            #1 check("t3_rdy", {31'b0, bus.in_ready}, 32'd1);
            tick();
            check("t3_y1", bus.Y1, 32'(i));
            check("t3_v1", {31'b0, bus.out1_valid}, 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("t3_cnt1", {28'b0, count1}, 32'd3);
        check("t3_cnt0", {28'b0, count0}, 32'd0);
        check("t3_v0_held", {31'b0, bus.out0_valid}, 32'd1);
        check("t3_y0_held", bus.Y0, 32'h55);
        bus.out0_ready = 1'b1;
        tick();

        // 4: alternating destinations, both consumers ready
        clear = 1'b1; tick(); clear = 1'b0;
        alt_s[0] = 1'b0; alt_d[0] = 32'd10;
        alt_s[1] = 1'b1; alt_d[1] = 32'd20;
        alt_s[2] = 1'b0; alt_d[2] = 32'd30;
        alt_s[3] = 1'b1; alt_d[3] = 32'd40;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.S = alt_s[i]; bus.D = alt_d[i];
            #1 check("t4_rdy", {31'b0, bus.in_ready}, 32'd1);
            tick();
            if (alt_s[i]) begin
                check("t4_y1", bus.Y1, alt_d[i]);
                check("t4_v1", {31'b0, bus.out1_valid}, 32'd1);
            end else begin
                check("t4_y0", bus.Y0, alt_d[i]);
                check("t4_v0", {31'b0, bus.out0_valid}, 32'd1);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        check("t4_cnt0", {28'b0, count0}, 32'd2);
        check("t4_cnt1", {28'b0, count1}, 32'd2);

        // 5: saturation at 15, then clear beats a coincident drain
        clear = 1'b1; tick(); clear = 1'b0;
        bus.in_valid = 1'b1; bus.S = 1'b0; bus.out0_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bus.D = 32'(i);
            tick();
        end
        check("t5_cnt0_14", {28'b0, count0}, 32'd14);
        tick();
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("t5_cnt0_sat", {28'b0, count0}, 32'd15);
        bus.in_valid = 1'b1; bus.D = 32'h99;
        tick();
        bus.in_valid = 1'b0;
        clear = 1'b1;
        check("t5_v0_pre", {31'b0, bus.out0_valid}, 32'd1);
        tick();
        clear = 1'b0;
        check("t5_clear_drain", {28'b0, count0}, 32'd0);
        check("t5_v0_post", {31'b0, bus.out0_valid}, 32'd0);

        // 6: async reset while both slots are FULL
        bus.out1_ready = 1'b1;
        bus.in_valid = 1'b1; bus.S = 1'b1; bus.D = 32'h77;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("t6_cnt1_pre", {28'b0, count1}, 32'd1);
        bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
        bus.in_valid = 1'b1; bus.S = 1'b0; bus.D = 32'hAA;
        tick();
        bus.S = 1'b1; bus.D = 32'hBB;
        tick();
        bus.in_valid = 1'b0;
        check("t6_y0_aa", bus.Y0, 32'hAA);
        check("t6_y1_bb", bus.Y1, 32'hBB);
        #2 reset_n = 1'b0;
        #1;
        check("t6_v0", {31'b0, bus.out0_valid}, 32'd0);
        check("t6_v1", {31'b0, bus.out1_valid}, 32'd0);
        check("t6_y0", bus.Y0, 32'd0);
        check("t6_y1", bus.Y1, 32'd0);
        check("t6_cnt0", {28'b0, count0}, 32'd0);
        check("t6_cnt1", {28'b0, count1}, 32'd0);
        #1 reset_n = 1'b1;
        bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
        tick();
        tick();
        check("t6_cnt0_after", {28'b0, count0}, 32'd0);
        check("t6_cnt1_after", {28'b0, count1}, 32'd0);
        check("t6_v0_after", {31'b0, bus.out0_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
